vx_warp_ctl_unit: RTL and testbench

// - Slave end of VX_warp_ctl_if: consumes warp-control requests (tmc, wspawn, barrier, split) from the GPU execute unit.
// - Owns per-warp active, thread-mask, stall and IPDOM-stack state; feeds the warp scheduler and fetch redirect.
// - One request per cycle; there is no back-pressure, so a request is accepted on every cycle valid=1.

---
 rtl/vx_warp_ctl_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_vx_warp_ctl_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_warp_ctl_unit.sv
`default_nettype none
// ============================================================================
// Module   : vx_warp_ctl_unit
// Purpose  : Warp-control slave. Consumes tmc / wspawn / split / barrier
//            requests and join events from the execute unit. Owns the
//            per-warp active mask, thread masks, barrier stalls and the
//            IPDOM divergence stack. Feeds the warp scheduler and fetch
//            redirect.
// Ports    : clk, reset_n          - clock, async active-low reset
//            ctl_*_i               - warp-control request (flattened
//                                    VX_warp_ctl_if slave side)
//            join_valid_i/wid_i    - join executed by a warp
//            active_warps_o        - warp active mask
//            stalled_warps_o       - warps held at a barrier
//            thread_masks_o        - warp w mask at [w*NT +: NT]
//            spawn_*_o             - one-cycle wspawn notification
//            redirect_*_o          - one-cycle else-path fetch redirect
//            stack_err_o           - sticky IPDOM overflow/underflow
// Config   : WCTL_BARRIER_EN       - define to build barrier logic;
//                                    otherwise stalled_warps_o is 0
// Revision : 1.0 - initial release
// ============================================================================
module vx_warp_ctl_unit #(
  parameter int NUM_WARPS    = 8,
  parameter int NUM_THREADS  = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int STACK_DEPTH  = 4,
  localparam int NW_BITS     = $clog2(NUM_WARPS),
  localparam int NB_BITS     = $clog2(NUM_BARRIERS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  // warp-control request
  input  logic                             ctl_valid_i,
  input  logic [NW_BITS-1:0]               ctl_wid_i,
  input  logic                             tmc_valid_i,
  input  logic [NUM_THREADS-1:0]           tmc_tmask_i,
  input  logic                             wspawn_valid_i,
  input  logic [NUM_WARPS-1:0]             wspawn_wmask_i,
  input  logic [31:0]                      wspawn_pc_i,
  input  logic                             barrier_valid_i,
  input  logic [NB_BITS-1:0]               barrier_id_i,
  input  logic [NW_BITS-1:0]               barrier_size_m1_i,
  input  logic                             split_valid_i,
  input  logic                             split_diverged_i,
  input  logic [NUM_THREADS-1:0]           split_then_tmask_i,
  input  logic [NUM_THREADS-1:0]           split_else_tmask_i,
  input  logic [31:0]                      split_pc_i,
  // join
  input  logic                             join_valid_i,
  input  logic [NW_BITS-1:0]               join_wid_i,
  // scheduler / fetch outputs
  output logic [NUM_WARPS-1:0]             active_warps_o,
  output logic [NUM_WARPS-1:0]             stalled_warps_o,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks_o,
  output logic                             spawn_valid_o,
  output logic [NUM_WARPS-1:0]             spawn_wmask_o,
  output logic [31:0]                      spawn_pc_o,
  output logic                             redirect_valid_o,
  output logic [NW_BITS-1:0]               redirect_wid_o,
  output logic [31:0]                      redirect_pc_o,
  output logic                             stack_err_o
);

  localparam int NW   = NUM_WARPS;
  localparam int NT   = NUM_THREADS;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // ft=1 marks an entry whose else path has already been taken; the next
  // join on it restores the pre-split mask instead of redirecting.
  typedef struct packed {
    logic          ft;
    logic [NT-1:0] orig;
    logic [31:0]   pc;
    logic [NT-1:0] els;
  } ipdom_t;

  logic [NW-1:0]      active_q, active_d;
  logic [NT-1:0]      tmask_q [NW];
  logic [NT-1:0]      tmask_d [NW];
  ipdom_t             stk_q   [NW][STACK_DEPTH];
  ipdom_t             stk_d   [NW][STACK_DEPTH];
  logic [SP_W-1:0]    sp_q    [NW];
  logic [SP_W-1:0]    sp_d    [NW];
  logic               err_q, err_d;
  logic               spawn_valid_q, spawn_valid_d;
  logic [NW-1:0]      spawn_wmask_q, spawn_wmask_d;
  logic [31:0]        spawn_pc_q, spawn_pc_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [NW_BITS-1:0] redirect_wid_q, redirect_wid_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;

  logic [SP_W-1:0]    join_sp;
  logic [SI_W-1:0]    join_top;
  logic [SP_W-1:0]    split_sp;
  logic [NW-1:0]      spawn_set;

  logic w_tmc, w_spawn, w_split;
  assign w_tmc   = ctl_valid_i & tmc_valid_i;
  assign w_spawn = ctl_valid_i & wspawn_valid_i;
  assign w_split = ctl_valid_i & split_valid_i & split_diverged_i;

  // Join is resolved first so a same-cycle request on the same warp sees
  // the post-join mask and stack pointer.
  always_comb begin
    active_d         = active_q;
    tmask_d          = tmask_q;
    stk_d            = stk_q;
    sp_d             = sp_q;
    err_d            = err_q;
    spawn_valid_d    = 1'b0;
    spawn_wmask_d    = spawn_wmask_q;
    spawn_pc_d       = spawn_pc_q;
    redirect_valid_d = 1'b0;
    redirect_wid_d   = redirect_wid_q;
    redirect_pc_d    = redirect_pc_q;
    join_sp          = sp_q[join_wid_i];
    join_top         = SI_W'(join_sp - SP_W'(1));
    split_sp         = '0;
    spawn_set        = wspawn_wmask_i & ~NW'(1);

    if (join_valid_i) begin
      if (join_sp == '0) begin
        err_d = 1'b1;
      end else if (stk_q[join_wid_i][join_top].ft) begin
        tmask_d[join_wid_i] = stk_q[join_wid_i][join_top].orig;
        sp_d[join_wid_i]    = join_sp - SP_W'(1);
      end else begin
        // Take the else path and leave the slot in place as fallthrough.
        tmask_d[join_wid_i]           = stk_q[join_wid_i][join_top].els;
        stk_d[join_wid_i][join_top].ft = 1'b1;
        redirect_valid_d              = 1'b1;
        redirect_wid_d                = join_wid_i;
        redirect_pc_d                 = stk_q[join_wid_i][join_top].pc;
      end
    end

    split_sp = sp_d[ctl_wid_i];
    if (w_split) begin
      if (split_sp == SP_W'(STACK_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        stk_d[ctl_wid_i][SI_W'(split_sp)] = '{ft:   1'b0,
                                             orig: tmask_d[ctl_wid_i],
                                             pc:   split_pc_i,
                                             els:  split_else_tmask_i};
        sp_d[ctl_wid_i] = split_sp + SP_W'(1);
      end
      tmask_d[ctl_wid_i] = split_then_tmask_i;
    end

    // tmc after split so it wins the thread mask of the same request.
    if (w_tmc) begin
      tmask_d[ctl_wid_i]  = tmc_tmask_i;
      active_d[ctl_wid_i] = |tmc_tmask_i;
    end

    // wspawn last: it ORs into whatever tmc produced; warp 0 is excluded.
    if (w_spawn) begin
      active_d = active_d | spawn_set;
      for (int w = 0; w < NW; w++) begin
        if (spawn_set[w]) tmask_d[w] = NT'(1);
      end
      spawn_valid_d = 1'b1;
      spawn_wmask_d = wspawn_wmask_i;
      spawn_pc_d    = wspawn_pc_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= NW'(1);
      for (int w = 0; w < NW; w++) begin
        tmask_q[w] <= (w == 0) ? NT'(1) : '0;
        sp_q[w]    <= '0;
        for (int s = 0; s < STACK_DEPTH; s++) begin
          stk_q[w][s] <= '0;
        end
      end
      err_q            <= 1'b0;
      spawn_valid_q    <= 1'b0;
      spawn_wmask_q    <= '0;
      spawn_pc_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_wid_q   <= '0;
      redirect_pc_q    <= '0;
    end else begin
      active_q         <= active_d;
      tmask_q          <= tmask_d;
      sp_q             <= sp_d;
      stk_q            <= stk_d;
      err_q            <= err_d;
      spawn_valid_q    <= spawn_valid_d;
      spawn_wmask_q    <= spawn_wmask_d;
      spawn_pc_q       <= spawn_pc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_wid_q   <= redirect_wid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

`ifdef WCTL_BARRIER_EN
  logic [NW-1:0] stalled_q, stalled_d;
  logic [NW-1:0] bar_q [NUM_BARRIERS];
  logic [NW-1:0] bar_d [NUM_BARRIERS];
  logic [NW-1:0] bar_arrive;

  // Arrivals are OR-ed into the barrier set, so repeats are harmless. The
  // last arrival releases everyone, itself included, and never stalls.
  always_comb begin
    stalled_d  = stalled_q;
    bar_d      = bar_q;
    bar_arrive = bar_q[barrier_id_i] | (NW'(1) << ctl_wid_i);
    if (ctl_valid_i && barrier_valid_i) begin
      if ($countones(bar_arrive) == int'(barrier_size_m1_i) + 1) begin
        stalled_d           = stalled_q & ~bar_arrive;
        bar_d[barrier_id_i] = '0;
      end else begin
        stalled_d[ctl_wid_i] = 1'b1;
        bar_d[barrier_id_i]  = bar_arrive;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stalled_q <= '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        bar_q[b] <= '0;
      end
    end else begin
      stalled_q <= stalled_d;
      bar_q     <= bar_d;
    end
  end

  assign stalled_warps_o = stalled_q;
`else
  logic w_unused_bar;
  assign w_unused_bar    = ^{barrier_valid_i, barrier_id_i, barrier_size_m1_i};
  assign stalled_warps_o = '0;
`endif

  for (genvar g = 0; g < NW; g++) begin : g_tmask_out
    assign thread_masks_o[g*NT +: NT] = tmask_q[g];
  end

  assign active_warps_o   = active_q;
  assign spawn_valid_o    = spawn_valid_q;
  assign spawn_wmask_o    = spawn_wmask_q;
  assign spawn_pc_o       = spawn_pc_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_wid_o   = redirect_wid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign stack_err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_warp_ctl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_warp_ctl_unit
// Purpose  : Self-checking bench for vx_warp_ctl_unit: vector table,
//            directed divergence / barrier / reset sequences, and random
//            traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_warp_ctl_unit;
  localparam int NW = 8;
  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctl_valid;
  logic [2:0]  ctl_wid;
  logic        tmc_valid;
  logic [3:0]  tmc_tmask;
  logic        wspawn_valid;
  logic [7:0]  wspawn_wmask;
  logic [31:0] wspawn_pc;
  logic        barrier_valid;
  logic [1:0]  barrier_id;
  logic [2:0]  barrier_size_m1;
  logic        split_valid;
  logic        split_diverged;
  logic [3:0]  split_then;
  logic [3:0]  split_else;
  logic [31:0] split_pc;
  logic        join_valid;
  logic [2:0]  join_wid;
  logic [7:0]  active_warps;
  logic [7:0]  stalled_warps;
  logic [31:0] thread_masks;
  logic        spawn_valid;
  logic [7:0]  spawn_wmask;
  logic [31:0] spawn_pc;
  logic        redirect_valid;
  logic [2:0]  redirect_wid;
  logic [31:0] redirect_pc;
  logic        stack_err;

  always #5 clk = ~clk;

  vx_warp_ctl_unit dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ctl_valid_i       (ctl_valid),
    .ctl_wid_i         (ctl_wid),
    .tmc_valid_i       (tmc_valid),
    .tmc_tmask_i       (tmc_tmask),
    .wspawn_valid_i    (wspawn_valid),
    .wspawn_wmask_i    (wspawn_wmask),
    .wspawn_pc_i       (wspawn_pc),
    .barrier_valid_i   (barrier_valid),
    .barrier_id_i      (barrier_id),
    .barrier_size_m1_i (barrier_size_m1),
    .split_valid_i     (split_valid),
    .split_diverged_i  (split_diverged),
    .split_then_tmask_i(split_then),
    .split_else_tmask_i(split_else),
    .split_pc_i        (split_pc),
    .join_valid_i      (join_valid),
    .join_wid_i        (join_wid),
    .active_warps_o    (active_warps),
    .stalled_warps_o   (stalled_warps),
    .thread_masks_o    (thread_masks),
    .spawn_valid_o     (spawn_valid),
    .spawn_wmask_o     (spawn_wmask),
    .spawn_pc_o        (spawn_pc),
    .redirect_valid_o  (redirect_valid),
    .redirect_wid_o    (redirect_wid),
    .redirect_pc_o     (redirect_pc),
    .stack_err_o       (stack_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        ft;
    bit [3:0]  orig;
    bit [31:0] pc;
    bit [3:0]  els;
  } ent_t;

  ent_t      m_stk [NW][$];
  bit [7:0]  m_active, m_stall;
  bit [3:0]  m_tm  [NW];
  bit [7:0]  m_bar [4];
  bit        m_err, m_spv, m_rv;
  bit [7:0]  m_spm;
  bit [31:0] m_spc, m_rpc;
  bit [2:0]  m_rw;

  task automatic model_reset();
    m_active = 8'h01;
    m_stall  = '0;
    for (int w = 0; w < NW; w++) begin
      m_tm[w] = (w == 0) ? 4'h1 : 4'h0;
      m_stk[w].delete();
    end
    for (int b = 0; b < 4; b++) m_bar[b] = '0;
    m_err = 0; m_spv = 0; m_rv = 0;
  endtask

  task automatic model_step();
    m_spv = 0;
    m_rv  = 0;
    if (join_valid) begin
      int   jw;
      ent_t e;
      jw = int'(join_wid);
      if (m_stk[jw].size() == 0) begin
        m_err = 1;
      end else begin
        e = m_stk[jw].pop_back();
        if (e.ft) begin
          m_tm[jw] = e.orig;
        end else begin
          m_tm[jw] = e.els;
          e.ft = 1;
          m_stk[jw].push_back(e);
          m_rv  = 1;
          m_rw  = join_wid;
          m_rpc = e.pc;
        end
      end
    end
    if (ctl_valid) begin
      int   w;
      ent_t n;
      w = int'(ctl_wid);
      if (split_valid && split_diverged) begin
        if (m_stk[w].size() >= 4) begin
          m_err = 1;
        end else begin
          n.ft = 0; n.orig = m_tm[w]; n.pc = split_pc; n.els = split_else;
          m_stk[w].push_back(n);
        end
        m_tm[w] = split_then;
      end
      if (tmc_valid) begin
        m_tm[w]     = tmc_tmask;
        m_active[w] = (tmc_tmask != 0);
      end
      if (wspawn_valid) begin
        for (int k = 1; k < NW; k++) begin
          if (wspawn_wmask[k]) begin
            m_active[k] = 1;
            m_tm[k]     = 4'h1;
          end
        end
        m_spv = 1; m_spm = wspawn_wmask; m_spc = wspawn_pc;
      end
`ifdef WCTL_BARRIER_EN
      if (barrier_valid) begin
        bit [7:0] set;
        set    = m_bar[barrier_id];
        set[w] = 1'b1;
        if ($countones(set) == int'(barrier_size_m1) + 1) begin
          m_stall = m_stall & ~set;
          m_bar[barrier_id] = '0;
        end else begin
          m_bar[barrier_id] = set;
          m_stall[w] = 1'b1;
        end
      end
`endif
    end
  endtask

  function automatic bit [31:0] tm_flat();
    bit [31:0] r;
    for (int w = 0; w < NW; w++) r[w*4 +: 4] = m_tm[w];
    return r;
  endfunction

  task automatic compare_all();
    chk("active", active_warps, m_active);
    chk("stalled", stalled_warps, m_stall);
    chk("tmasks", thread_masks, tm_flat());
    chk("spawn_valid", spawn_valid, m_spv);
    if (m_spv) begin
      chk("spawn_wmask", spawn_wmask, m_spm);
      chk("spawn_pc", spawn_pc, m_spc);
    end
    chk("redirect_valid", redirect_valid, m_rv);
    if (m_rv) begin
      chk("redirect_wid", redirect_wid, m_rw);
      chk("redirect_pc", redirect_pc, m_rpc);
    end
    chk("stack_err", stack_err, m_err);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ctl_valid = 0; ctl_wid = '0;
    tmc_valid = 0; tmc_tmask = '0;
    wspawn_valid = 0; wspawn_wmask = '0; wspawn_pc = '0;
    barrier_valid = 0; barrier_id = '0; barrier_size_m1 = '0;
    split_valid = 0; split_diverged = 0; split_then = '0; split_else = '0; split_pc = '0;
    join_valid = 0; join_wid = '0;
  endtask

  // Inputs are stable across the edge; outputs sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    idle();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_active"}, active_warps, 8'h01);
    chk({tag, "_tmasks"}, thread_masks, 32'h0000_0001);
    chk({tag, "_stalled"}, stalled_warps, 8'h00);
    chk({tag, "_stack_err"}, stack_err, 1'b0);
    chk({tag, "_spawn_valid"}, spawn_valid, 1'b0);
    chk({tag, "_redirect_valid"}, redirect_valid, 1'b0);
  endtask

  // Called 1ns after an edge: assert reset between edges, check at once.
  task automatic async_reset(input string tag);
    #1 reset_n = 1'b0;
    #1 check_reset_state(tag);
    model_reset();
    idle();
    #10 reset_n = 1'b1;
  endtask

  task automatic do_split(input int w, input bit [3:0] th, input bit [3:0] el, input bit [31:0] pc);
    ctl_valid = 1; ctl_wid = 3'(w);
    split_valid = 1; split_diverged = 1; split_then = th; split_else = el; split_pc = pc;
    cycle();
  endtask

  task automatic do_join(input int w);
    join_valid = 1; join_wid = 3'(w);
    cycle();
  endtask

  task automatic do_tmc(input int w, input bit [3:0] m);
    ctl_valid = 1; ctl_wid = 3'(w); tmc_valid = 1; tmc_tmask = m;
    cycle();
  endtask

`ifdef WCTL_BARRIER_EN
  task automatic do_bar(input int w, input int id, input int sm1);
    ctl_valid = 1; ctl_wid = 3'(w);
    barrier_valid = 1; barrier_id = 2'(id); barrier_size_m1 = 3'(sm1);
    cycle();
  endtask
`endif

  typedef struct {
    bit        tmc_v;
    bit [2:0]  wid;
    bit [3:0]  tmask;
    bit        ws_v;
    bit [7:0]  wmask;
    bit [31:0] pc;
    bit [7:0]  e_active;
    bit [31:0] e_tm;
    bit        e_spv;
    bit [7:0]  e_spm;
    bit [31:0] e_spc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1, 3'd3, 4'hA, 0, 8'h00, 32'h0,         8'h09, 32'h0000_A001, 0, 8'h00, 32'h0};
    tbl[1] = '{1, 3'd3, 4'h0, 0, 8'h00, 32'h0,         8'h01, 32'h0000_0001, 0, 8'h00, 32'h0};
    tbl[2] = '{0, 3'd0, 4'h0, 1, 8'hFF, 32'h8000_0100, 8'hFF, 32'h1111_1111, 1, 8'hFF, 32'h8000_0100};
    tbl[3] = '{0, 3'd0, 4'h0, 0, 8'h00, 32'h0,         8'hFF, 32'h1111_1111, 0, 8'h00, 32'h0};
    tbl[4] = '{1, 3'd0, 4'h0, 1, 8'h01, 32'h0000_1234, 8'hFE, 32'h1111_1110, 1, 8'h01, 32'h0000_1234};
    tbl[5] = '{1, 3'd5, 4'hF, 1, 8'h20, 32'h0000_0040, 8'hFE, 32'h1111_1110, 1, 8'h20, 32'h0000_0040};
    tbl[6] = '{1, 3'd0, 4'h3, 0, 8'h00, 32'h0,         8'hFF, 32'h1111_1113, 0, 8'h00, 32'h0};

    idle();
    reset_n = 1'b0;
    model_reset();
    #12 reset_n = 1'b1;
    #1 check_reset_state("reset");

    // vector table: tmc / wspawn and their interaction
    for (int i = 0; i < 7; i++) begin
      ctl_valid    = tbl[i].tmc_v | tbl[i].ws_v;
      ctl_wid      = tbl[i].wid;
      tmc_valid    = tbl[i].tmc_v;
      tmc_tmask    = tbl[i].tmask;
      wspawn_valid = tbl[i].ws_v;
      wspawn_wmask = tbl[i].wmask;
      wspawn_pc    = tbl[i].pc;
      cycle();
      chk($sformatf("vec%0d_active", i), active_warps, tbl[i].e_active);
      chk($sformatf("vec%0d_tmasks", i), thread_masks, tbl[i].e_tm);
      chk($sformatf("vec%0d_spawn_valid", i), spawn_valid, tbl[i].e_spv);
      if (tbl[i].e_spv) begin
        chk($sformatf("vec%0d_spawn_wmask", i), spawn_wmask, tbl[i].e_spm);
        chk($sformatf("vec%0d_spawn_pc", i), spawn_pc, tbl[i].e_spc);
      end
    end

    // divergence on warp 2
    do_tmc(2, 4'hF);
    ctl_valid = 1; ctl_wid = 3'd2; split_valid = 1; split_diverged = 0; split_then = 4'h1;
    cycle();
    chk("split_nodiv_tm2", thread_masks[11:8], 4'hF);
    do_split(2, 4'h3, 4'hC, 32'h0000_0200);
    chk("split_tm2", thread_masks[11:8], 4'h3);
    do_join(2);
    chk("join1_tm2", thread_masks[11:8], 4'hC);
    chk("join1_redirect_valid", redirect_valid, 1'b1);
    chk("join1_redirect_pc", redirect_pc, 32'h0000_0200);
    chk("join1_redirect_wid", redirect_wid, 3'd2);
    do_join(2);
    chk("join2_tm2", thread_masks[11:8], 4'hF);
    chk("join2_redirect_valid", redirect_valid, 1'b0);
    chk("join2_stack_err", stack_err, 1'b0);
    do_join(2);
    chk("underflow_stack_err", stack_err, 1'b1);
    chk("underflow_tm2", thread_masks[11:8], 4'hF);
    async_reset("rst_after_underflow");

    // overflow on warp 0, then reset mid-sequence
    for (int i = 0; i < 5; i++) begin
      do_split(0, 4'h1, 4'h0, 32'(i));
      chk($sformatf("ovf_split%0d_stack_err", i), stack_err, (i == 4));
    end
    async_reset("rst_after_overflow");

`ifdef WCTL_BARRIER_EN
    ctl_valid = 1; wspawn_valid = 1; wspawn_wmask = 8'hFF; wspawn_pc = 32'h100;
    cycle();
    do_bar(0, 1, 2); chk("bar_w0_stalled", stalled_warps, 8'h01);
    do_bar(1, 1, 2); chk("bar_w1_stalled", stalled_warps, 8'h03);
    do_bar(2, 1, 2); chk("bar_w2_release", stalled_warps, 8'h00);
    do_bar(0, 1, 1); chk("bar_rep1_stalled", stalled_warps, 8'h01);
    do_bar(0, 1, 1); chk("bar_rep2_stalled", stalled_warps, 8'h01);
    do_bar(3, 1, 1); chk("bar_rep_release", stalled_warps, 8'h00);
    do_bar(4, 1, 1); chk("bar_cleared_stalled", stalled_warps, 8'h10);
    do_tmc(4, 4'h0);
    chk("bar_tmc0_active", active_warps[4], 1'b0);
    chk("bar_tmc0_stalled", stalled_warps, 8'h10);
    do_bar(5, 1, 1); chk("bar_w5_release", stalled_warps, 8'h00);
    async_reset("rst_after_barrier");
`endif

    // random traffic against the model, two runs split by a reset
    for (int run = 0; run < 2; run++) begin
      ctl_valid = 1; wspawn_valid = 1; wspawn_wmask = 8'hFF; wspawn_pc = 32'h8000_0000;
      cycle();
      for (int c = 0; c < 300; c++) begin
        ctl_valid       = ($urandom % 4) != 0;
        ctl_wid         = 3'($urandom_range(0, (run == 0) ? 3 : 7));
        tmc_valid       = ($urandom % 5) == 0;
        tmc_tmask       = (($urandom % 4) == 0) ? 4'h0 : 4'($urandom);
        wspawn_valid    = ($urandom % 10) == 0;
        wspawn_wmask    = 8'($urandom);
        wspawn_pc       = $urandom;
        barrier_valid   = ($urandom % 4) == 0;
        barrier_id      = 2'($urandom);
        barrier_size_m1 = 3'($urandom_range(0, 3));
        split_valid     = ($urandom % 3) == 0;
        split_diverged  = ($urandom % 4) != 0;
        split_then      = 4'($urandom);
        split_else      = 4'($urandom);
        split_pc        = $urandom;
        join_valid      = ($urandom % 3) == 0;
        join_wid        = 3'($urandom_range(0, (run == 0) ? 3 : 7));
        cycle();
      end
      async_reset($sformatf("rst_after_random%0d", run));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
